// File: rtl/conv_sched_pkg.sv
// Shared FSM encoding and width helpers for the 1x1 convolution scheduler.
package conv_sched_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_FETCH = 3'd1;
  localparam logic [2:0] ST_ISSUE = 3'd2;
  localparam logic [2:0] ST_DRAIN = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  // Counter width for a range of n values; never narrower than one bit.
  function automatic int cw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int DEF_NUM_K      = 4;
  localparam int DEF_IMG_WIDTH  = 3;
  localparam int DEF_IMG_HEIGHT = 3;
  localparam int DEF_K_W        = cw(DEF_NUM_K);
  localparam int DEF_COL_W      = cw(DEF_IMG_WIDTH);
  localparam int DEF_ROW_W      = cw(DEF_IMG_HEIGHT);

endpackage

// File: rtl/conv1x1_scheduler_if.sv
// Scheduler <-> 1x1 processing element bus: issue strobe out, result back.
interface conv1x1_scheduler_if #(
  parameter int Datawidth = 16
) ();
  logic [Datawidth-1:0] PE_In;
  logic [Datawidth-1:0] PE_K;
  logic                 PE_Valid_IN;
  logic [Datawidth-1:0] PE_Out;
  logic                 PE_Valid_OUT;

  modport master (
    output PE_In, PE_K, PE_Valid_IN,
    input  PE_Out, PE_Valid_OUT
  );

  modport slave (
    input  PE_In, PE_K, PE_Valid_IN,
    output PE_Out, PE_Valid_OUT
  );
endinterface

// File: rtl/conv1x1_weight_rf.sv
// Per-kernel weight register file: sync write, async read, async clear.
module conv1x1_weight_rf
  import conv_sched_pkg::*;
#(
  parameter int NUM_K     = 4,
  parameter int Datawidth = 16,
  parameter int AW        = cw(NUM_K)
) (
  input  logic                 CLK,
  input  logic                 CLR,
  input  logic                 we,
  input  logic [AW-1:0]        waddr,
  input  logic [Datawidth-1:0] wdata,
  input  logic [AW-1:0]        raddr,
  output logic [Datawidth-1:0] rdata
);

  logic [Datawidth-1:0] mem [NUM_K];

  // Decode by index match so addresses beyond NUM_K-1 simply hit nothing.
  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      for (int i = 0; i < NUM_K; i++) mem[i] <= '0;
    end else if (we) begin
      for (int i = 0; i < NUM_K; i++)
        if (waddr == AW'(i)) mem[i] <= wdata;
    end
  end

  always_comb begin
    rdata = '0;
    for (int i = 0; i < NUM_K; i++)
      if (raddr == AW'(i)) rdata = mem[i];
  end

endmodule

// File: rtl/conv1x1_scheduler.sv
// Streams a feature map pixel-by-pixel through a 1x1 PE, issuing one weight
// per cycle and re-tagging PE results with channel/column/row.
//
// state | meaning
// IDLE  | waiting for Start, weights writable
// FETCH | In_Ready high, waiting for a pixel
// ISSUE | one PE issue per kernel for the held pixel
// DRAIN | last issue in flight through the PE
// DONE  | one-cycle frame-complete pulse
module conv1x1_scheduler
  import conv_sched_pkg::*;
#(
  parameter  int IMG_Width  = 3,
  parameter  int IMG_Height = 3,
  parameter  int Datawidth  = 16,
  parameter  int NUM_K      = 4,
  localparam int KW         = cw(NUM_K),
  localparam int CW         = cw(IMG_Width),
  localparam int RW         = cw(IMG_Height)
) (
  input  logic                 CLK,
  input  logic                 CLR,
  input  logic                 Start,
  input  logic                 W_WE,
  input  logic [KW-1:0]        W_ADDR,
  input  logic [Datawidth-1:0] W_DATA,
  input  logic [Datawidth-1:0] In_Data,
  input  logic                 In_Valid,
  output logic                 In_Ready,
  conv1x1_scheduler_if.master  pe,
  output logic [Datawidth-1:0] Out_Data,
  output logic                 Out_Valid,
  output logic [KW-1:0]        Out_Ch,
  output logic [CW-1:0]        Out_Col,
  output logic [RW-1:0]        Out_Row,
  output logic                 Out_Last,
  output logic                 Busy,
  output logic                 Done
);

  localparam logic [KW-1:0] K_LAST   = KW'(NUM_K - 1);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_Width - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_Height - 1);

  logic [2:0]           state;
  logic [KW-1:0]        k;
  logic [CW-1:0]        col;
  logic [RW-1:0]        row;
  logic [Datawidth-1:0] pix;
  logic [Datawidth-1:0] pe_in_q;
  logic [Datawidth-1:0] pe_k_q;
  logic [Datawidth-1:0] w_rd;
  logic [KW-1:0]        tag_k;
  logic [CW-1:0]        tag_col;
  logic [RW-1:0]        tag_row;
  logic                 tag_last;
  logic                 issue;
  logic                 k_last;
  logic                 col_last;
  logic                 row_last;

  assign issue    = (state == ST_ISSUE);
  assign k_last   = (k == K_LAST);
  assign col_last = (col == COL_LAST);
  assign row_last = (row == ROW_LAST);

  assign In_Ready = (state == ST_FETCH);
  assign Busy     = (state != ST_IDLE);
  assign Done     = (state == ST_DONE);

  // PE operands are live during ISSUE and otherwise hold the last issued pair.
  assign pe.PE_Valid_IN = issue;
  assign pe.PE_In       = issue ? pix  : pe_in_q;
  assign pe.PE_K        = issue ? w_rd : pe_k_q;

  conv1x1_weight_rf #(
    .NUM_K     (NUM_K),
    .Datawidth (Datawidth),
    .AW        (KW)
  ) u_weight_rf (
    .CLK   (CLK),
    .CLR   (CLR),
    .we    (W_WE && (state == ST_IDLE)),
    .waddr (W_ADDR),
    .wdata (W_DATA),
    .raddr (k),
    .rdata (w_rd)
  );

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      state    <= ST_IDLE;
      k        <= '0;
      col      <= '0;
      row      <= '0;
      pix      <= '0;
      pe_in_q  <= '0;
      pe_k_q   <= '0;
      tag_k    <= '0;
      tag_col  <= '0;
      tag_row  <= '0;
      tag_last <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (Start) begin
            state <= ST_FETCH;
            k     <= '0;
            col   <= '0;
            row   <= '0;
          end
        end
        ST_FETCH: begin
          if (In_Valid) begin
            pix   <= In_Data;
            k     <= '0;
            state <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          pe_in_q  <= pix;
          pe_k_q   <= w_rd;
          tag_k    <= k;
          tag_col  <= col;
          tag_row  <= row;
          tag_last <= k_last && col_last && row_last;
          if (k_last) begin
            k <= '0;
            if (col_last) begin
              col <= '0;
              if (row_last) begin
                row   <= '0;
                state <= ST_DRAIN;
              end else begin
                row   <= row + 1'b1;
                state <= ST_FETCH;
              end
            end else begin
              col   <= col + 1'b1;
              state <= ST_FETCH;
            end
          end else begin
            k <= k + 1'b1;
          end
        end
        ST_DRAIN: state <= ST_DONE;
        ST_DONE:  state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  // Results are forwarded whenever the PE says valid, using whatever tag is held.
  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      Out_Valid <= 1'b0;
      Out_Last  <= 1'b0;
      Out_Data  <= '0;
      Out_Ch    <= '0;
      Out_Col   <= '0;
      Out_Row   <= '0;
    end else begin
      Out_Valid <= pe.PE_Valid_OUT;
      Out_Last  <= pe.PE_Valid_OUT && tag_last;
      if (pe.PE_Valid_OUT) begin
        Out_Data <= pe.PE_Out;
        Out_Ch   <= tag_k;
        Out_Col  <= tag_col;
        Out_Row  <= tag_row;
      end
    end
  end

endmodule

// File: tb/tb_conv1x1_scheduler.sv
// Directed bench for conv1x1_scheduler with a 1-cycle multiply PE model.
module tb_conv1x1_scheduler;
  import conv_sched_pkg::*;

  localparam int W  = 3;
  localparam int H  = 3;
  localparam int DW = 16;
  localparam int K  = 4;
  localparam int NRES = W * H * K;

  logic          CLK = 1'b0;
  logic          CLR = 1'b0;
  logic          Start = 1'b0;
  logic          W_WE = 1'b0;
  logic [1:0]    W_ADDR = '0;
  logic [DW-1:0] W_DATA = '0;
  logic [DW-1:0] In_Data = '0;
  logic          In_Valid = 1'b0;
  logic          In_Ready;
  logic [DW-1:0] Out_Data;
  logic          Out_Valid;
  logic [1:0]    Out_Ch;
  logic [1:0]    Out_Col;
  logic [1:0]    Out_Row;
  logic          Out_Last;
  logic          Busy;
  logic          Done;

  conv1x1_scheduler_if #(.Datawidth(DW)) pe_if ();

  conv1x1_scheduler #(
    .IMG_Width  (W),
    .IMG_Height (H),
    .Datawidth  (DW),
    .NUM_K      (K)
  ) dut (
    .CLK       (CLK),
    .CLR       (CLR),
    .Start     (Start),
    .W_WE      (W_WE),
    .W_ADDR    (W_ADDR),
    .W_DATA    (W_DATA),
    .In_Data   (In_Data),
    .In_Valid  (In_Valid),
    .In_Ready  (In_Ready),
    .pe        (pe_if),
    .Out_Data  (Out_Data),
    .Out_Valid (Out_Valid),
    .Out_Ch    (Out_Ch),
    .Out_Col   (Out_Col),
    .Out_Row   (Out_Row),
    .Out_Last  (Out_Last),
    .Busy      (Busy),
    .Done      (Done)
  );

  always #5 CLK = ~CLK;

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      pe_if.PE_Valid_OUT <= 1'b0;
      pe_if.PE_Out       <= '0;
    end else begin
      pe_if.PE_Valid_OUT <= pe_if.PE_Valid_IN;
      pe_if.PE_Out       <= pe_if.PE_In * pe_if.PE_K;
    end
  end

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  int cyc = 0;
  always @(posedge CLK) cyc++;

  logic [DW-1:0] w_exp [K];
  int n_out = 0, n_done = 0, n_last = 0, done_cyc = 0;
  int mon_p, mon_ch;
  logic [22:0] mon_exp;

  // Results must appear in raster order, channel innermost, data = pixel * weight.
  always @(negedge CLK) begin
    if (Out_Valid) begin
      mon_p   = n_out / K;
      mon_ch  = n_out % K;
      mon_exp = {16'((mon_p + 1) * int'(w_exp[mon_ch])), 2'(mon_ch), 2'(mon_p % W),
                 2'(mon_p / W), (n_out == NRES - 1)};
      chk("out", {Out_Data, Out_Ch, Out_Col, Out_Row, Out_Last}, mon_exp);
      n_out++;
    end
    if (Out_Last) n_last++;
    if (Done) begin
      n_done++;
      done_cyc = cyc;
    end
  end

  task automatic load_w(input logic [DW-1:0] a, input logic [DW-1:0] b,
                        input logic [DW-1:0] c, input logic [DW-1:0] d);
    logic [DW-1:0] v [K];
    v[0] = a; v[1] = b; v[2] = c; v[3] = d;
    for (int i = 0; i < K; i++) begin
      W_WE = 1'b1; W_ADDR = 2'(i); W_DATA = v[i];
      @(negedge CLK);
      w_exp[i] = v[i];
    end
    W_WE = 1'b0;
  endtask

  task automatic run_frame(input bit gap, input bit pulse_start, input bit wwe_busy, input int rst_pix);
    int t;
    int start_cyc;
    n_out = 0; n_done = 0; n_last = 0;
    Start = 1'b1;
    @(negedge CLK);
    Start = 1'b0;
    start_cyc = cyc;
    chk("busy_start", Busy, 1);
    for (int p = 0; p < W * H; p++) begin
      In_Data  = DW'(p + 1);
      In_Valid = !(gap && p == 1);
      t = 0;
      while (!In_Ready && t < 50) begin
        @(negedge CLK);
        t++;
      end
      if (t >= 50) chk("fetch_timeout", 0, 1);
      if (gap && p == 1) begin
        repeat (3) begin
          chk("gap_ready", In_Ready, 1);
          chk("gap_pe_valid", pe_if.PE_Valid_IN, 0);
          @(negedge CLK);
        end
        In_Valid = 1'b1;
      end
      @(negedge CLK);
      if (p == 0) begin
        chk("issue_valid", pe_if.PE_Valid_IN, 1);
        chk("issue_pix", pe_if.PE_In, 1);
        chk("issue_k0", pe_if.PE_K, w_exp[0]);
      end
      if (pulse_start && p == 4) begin
        Start = 1'b1;
        @(negedge CLK);
        Start = 1'b0;
      end
      if (wwe_busy && p == 2) begin
        W_WE = 1'b1; W_ADDR = 2'd1; W_DATA = 16'd7;
        @(negedge CLK);
        W_WE = 1'b0;
      end
      if (rst_pix >= 0 && p == rst_pix) begin
        CLR = 1'b0;
        #1;
        chk("rst_busy", Busy, 0);
        chk("rst_ready", In_Ready, 0);
        chk("rst_pe_valid", pe_if.PE_Valid_IN, 0);
        chk("rst_pe_in", pe_if.PE_In, 0);
        chk("rst_pe_k", pe_if.PE_K, 0);
        chk("rst_out", {Out_Valid, Out_Last, Done, Out_Data, Out_Ch, Out_Col, Out_Row}, 0);
        n_out = 0; n_done = 0; n_last = 0;
        In_Valid = 1'b0;
        repeat (2) @(negedge CLK);
        CLR = 1'b1;
        repeat (6) @(negedge CLK);
        chk("rst_no_out", n_out, 0);
        chk("rst_no_done", n_done, 0);
        chk("rst_idle", Busy, 0);
        return;
      end
    end
    In_Valid = 1'b0;
    t = 0;
    while (n_done == 0 && t < 100) begin
      @(negedge CLK);
      t++;
    end
    if (t >= 100) chk("done_timeout", 0, 1);
    repeat (4) @(negedge CLK);
    chk("n_out", n_out, NRES);
    chk("n_done", n_done, 1);
    chk("n_last", n_last, 1);
    chk("busy_end", Busy, 0);
    if (!gap) chk("frame_len", done_cyc - start_cyc + 1, (K + 1) * W * H + 2);
  endtask

  initial begin
    for (int i = 0; i < K; i++) w_exp[i] = '0;
    #2;
    chk("reset_busy", Busy, 0);
    chk("reset_ready", In_Ready, 0);
    chk("reset_outs", {Out_Valid, Out_Last, Done, pe_if.PE_Valid_IN, Out_Data}, 0);
    repeat (2) @(negedge CLK);
    CLR = 1'b1;
    @(negedge CLK);

    load_w(16'd1, 16'd2, 16'd3, 16'd4);
    run_frame(1'b0, 1'b0, 1'b0, -1);
    run_frame(1'b1, 1'b0, 1'b0, -1);
    run_frame(1'b0, 1'b0, 1'b1, -1);
    run_frame(1'b0, 1'b0, 1'b0, -1);
    run_frame(1'b0, 1'b1, 1'b0, -1);
    run_frame(1'b0, 1'b0, 1'b0, 3);
    for (int i = 0; i < K; i++) w_exp[i] = '0;
    run_frame(1'b0, 1'b0, 1'b0, -1);
    load_w(16'd1, 16'd2, 16'd3, 16'd4);
    run_frame(1'b0, 1'b0, 1'b0, -1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/conv1x1_scheduler.md
CONV1X1_SCHEDULER -- requirements
Module: conv1x1_scheduler

Interface
REQ-001 SHALL have parameters: IMG_Width, 3, feature-map columns; IMG_Height, 3, feature-map rows; Datawidth, 16, pixel/weight/result width; NUM_K, 4, output channels (kernels) per pixel.
REQ-002 SHALL have ports, one clock, reset asynchronous active-low:
- CLK in 1, rising-edge clock.
- CLR in 1, asynchronous active-low reset.
- Start in 1, one-cycle frame start request.
- W_WE in 1, weight write enable.
- W_ADDR in clog2(NUM_K), weight index.
- W_DATA in Datawidth, weight value.
- In_Data in Datawidth, input pixel.
- In_Valid in 1, pixel valid.
- In_Ready out 1, pixel accepted when In_Valid&In_Ready.
- PE_In out Datawidth, pixel to the 1x1 PE.
- PE_K out Datawidth, weight to the 1x1 PE.
- PE_Valid_IN out 1, PE issue strobe.
- PE_Out in Datawidth, PE result (1-cycle PE latency).
- PE_Valid_OUT in 1, PE result valid.
- Out_Data out Datawidth, result.
- Out_Valid out 1, result valid.
- Out_Ch out clog2(NUM_K), result channel.
- Out_Col out clog2(IMG_Width), result column.
- Out_Row out clog2(IMG_Height), result row.
- Out_Last out 1, final result of frame.
- Busy out 1, frame in progress.
- Done out 1, one-cycle frame-complete pulse.

Function
REQ-003 SHALL implement FSM IDLE, FETCH, ISSUE, DRAIN, DONE.
REQ-004 IDLE: Busy=0, In_Ready=0; Start=1 -> FETCH, col=row=k=0.
REQ-005 FETCH: In_Ready=1; on handshake latch In_Data into pixel register, k=0 -> ISSUE; no handshake -> stay.
REQ-006 ISSUE: each cycle PE_Valid_IN=1, PE_In=pixel register, PE_K=weight[k], tag {k,col,row} into one-stage tag register; k increments.
REQ-007 ISSUE at k=NUM_K-1: col increments; col wrap at IMG_Width-1 -> col=0, row increments; last pixel (col=IMG_Width-1, row=IMG_Height-1) -> DRAIN, else -> FETCH.
REQ-008 DRAIN: one cycle, no issue, awaits final PE result -> DONE.
REQ-009 DONE: Done=1 one cycle, Busy=0 from next cycle -> IDLE.
REQ-010 Busy=1 in FETCH, ISSUE, DRAIN, DONE.
REQ-011 Out_Valid, Out_Data, Out_Ch/Col/Row SHALL be registered from PE_Valid_OUT, PE_Out and tag register; 2 cycles from issue to Out_Valid.
REQ-012 Out_Last=1 with the Out_Valid of channel NUM_K-1 of pixel (IMG_Width-1, IMG_Height-1), else 0.
REQ-013 Start while Busy SHALL be ignored; Start and Done in the same cycle ignores Start.
REQ-014 W_WE while Busy=0 writes weight[W_ADDR]; W_WE while Busy=1 SHALL be ignored; W_ADDR>=NUM_K ignored.
REQ-015 PE_Valid_IN SHALL be 0 outside ISSUE; PE_In/PE_K hold last values.
REQ-016 PE_Valid_OUT outside expected slot SHALL still forward with the current tag (no checking).
REQ-017 Frame throughput: (NUM_K+1)*IMG_Width*IMG_Height+2 cycles from Start with In_Valid held 1.

Reset
REQ-018 CLR=0 SHALL asynchronously force IDLE, counters 0, pixel register 0, all weights 0, all outputs 0.
REQ-019 Reset mid-frame SHALL abandon the frame; no Done, no further Out_Valid.

Structure
REQ-020 State encoding and counter-width constants SHALL live in shared package conv_sched_pkg.
REQ-021 Weight storage SHALL be sub-module conv1x1_weight_rf (NUM_K x Datawidth, async read, sync write, async reset).

Verification
REQ-022 Weights {1,2,3,4}, 3x3 pixels 1..9, In_Valid=1, PE model In*K -> 36 Out_Valid, pixel 5 gives 5,10,15,20 on Ch 0..3, Out_Last on 36th only, Done once.
REQ-023 In_Valid low 3 cycles before pixel 2 -> In_Ready held, no PE_Valid_IN in gap, results unchanged.
REQ-024 W_WE addr 1 data 7 while Busy -> no effect; after Done, rerun gives Ch1 = 2*pixel.
REQ-025 Start pulsed mid-frame -> ignored; exactly 36 results, one Done.
REQ-026 CLR low during pixel 4 ISSUE -> all outputs 0 next edge, weights 0; new Start after reload gives full correct frame.
